// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Loaded values are held pending and committed only at frame wrap, so a number is never shown half-updated.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic        pending,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int P_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [P_W-1:0] r_p;
  logic [1:0]     r_d;
  logic [15:0]    r_pv;
  logic           r_flag;
  logic [15:0]    r_disp;
  logic [3:0]     r_an;
  logic [6:0]     r_seg;

  logic           w_tick;
  logic           w_commit;
  logic [3:0]     w_nib;
  logic           w_blank;
  logic [6:0]     w_dec;

  assign w_tick   = (r_p == P_W'(REFRESH_DIV - 1));
  assign w_commit = w_tick && (r_d == 2'd3) && r_flag;

  // Digit k blanks when it and every more-significant nibble are zero; digit 0 always shows.
  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    case (r_d)
      2'd0: begin
        w_nib   = r_disp[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_nib   = r_disp[7:4];
        w_blank = blank_lz && (r_disp[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib   = r_disp[11:8];
        w_blank = blank_lz && (r_disp[15:8] == 8'h00);
      end
      default: begin
        w_nib   = r_disp[15:12];
        w_blank = blank_lz && (r_disp[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    w_dec = 7'h7F;
    case (w_nib)
      4'h0: w_dec = 7'h40;
      4'h1: w_dec = 7'h79;
      4'h2: w_dec = 7'h24;
      4'h3: w_dec = 7'h30;
      4'h4: w_dec = 7'h19;
      4'h5: w_dec = 7'h12;
      4'h6: w_dec = 7'h02;
      4'h7: w_dec = 7'h78;
      4'h8: w_dec = 7'h00;
      4'h9: w_dec = 7'h10;
      4'hA: w_dec = 7'h08;
      4'hB: w_dec = 7'h03;
      4'hC: w_dec = 7'h46;
      4'hD: w_dec = 7'h21;
      4'hE: w_dec = 7'h06;
      default: w_dec = 7'h0E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p    <= '0;
      r_d    <= 2'd0;
      r_pv   <= 16'h0000;
      r_flag <= 1'b0;
      r_disp <= 16'h0000;
      r_an   <= 4'hF;
      r_seg  <= 7'h7F;
    end else begin
      if (w_tick) begin
        r_p <= '0;
        r_d <= r_d + 2'd1;
      end else begin
        r_p <= r_p + P_W'(1);
      end
      // Commit reads the pv held before this edge; a same-edge load keeps the flag set.
      if (w_commit) r_disp <= r_pv;
      if (load) begin
        r_pv   <= value;
        r_flag <= 1'b1;
      end else if (w_commit) begin
        r_flag <= 1'b0;
      end
      r_an  <= ~(4'b0001 << r_d);
      r_seg <= w_blank ? 7'h7F : w_dec;
    end
  end

  assign pending = r_flag;
  assign an      = r_an;
  assign seg     = r_seg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4 (16-cycle frame).
// Edge counter n counts rising edges since reset release; commit edges are multiples of 16.
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks;
  int failures;
  int n;

  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .pending  (pending),
    .an       (an),
    .seg      (seg)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s n=%0d obs=%h exp=%h", tag, n, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic go_to(input int target);
    while (n < target) cyc();
  endtask

  task automatic go_frame();
    while ((n % 16) != 0) cyc();
  endtask

  task automatic commit_value(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    cyc();
    load  = 1'b0;
    go_frame();
  endtask

  // Checks one full frame: digit k is shown after edges base+1+4k .. base+4+4k.
  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an  [4];
    int base;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    exp_an[0] = 4'hE; exp_an[1] = 4'hD; exp_an[2] = 4'hB; exp_an[3] = 4'h7;
    go_frame();
    base = n;
    for (int k = 0; k < 4; k++) begin
      go_to(base + 1 + 4 * k);
      check({tag, "_an"}, {12'h0, an}, {12'h0, exp_an[k]});
      check({tag, "_seg"}, {9'h0, seg}, {9'h0, exp_seg[k]});
    end
  endtask

  task automatic hold_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("rst_an", {12'h0, an}, 16'h000F);
      check("rst_seg", {9'h0, seg}, 16'h007F);
      check("rst_pending", {15'h0, pending}, 16'h0000);
    end
    reset = 1'b0;
    n = 0;
  endtask

  initial begin
    logic [3:0] scan_an [4];
    checks = 0; failures = 0; n = 0;
    reset = 1'b1; value = 16'h0000; load = 1'b0; blank_lz = 1'b0;
    scan_an[0] = 4'hE; scan_an[1] = 4'hD; scan_an[2] = 4'hB; scan_an[3] = 4'h7;
    #2;

    // Reset and basic scan: each anode for 4 cycles, '0' everywhere
    hold_reset(3);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      check("scan_an", {12'h0, an}, {12'h0, scan_an[((i - 1) >> 2) & 3]});
      check("scan_seg", {9'h0, seg}, 16'h0040);
    end

    // Load 1A2F while d=1 (edges 20..23 leave d=1), commit at edge 32
    go_to(20);
    value = 16'h1A2F;
    load  = 1'b1;
    cyc();
    load  = 1'b0;
    check("ld_pending_rise", {15'h0, pending}, 16'h0001);
    go_to(31);
    check("ld_pending_hold", {15'h0, pending}, 16'h0001);
    cyc();
    check("ld_pending_fall", {15'h0, pending}, 16'h0000);
    check_frame("f1a2f", 7'h0E, 7'h24, 7'h08, 7'h79);

    // Leading-zero blanking, then disabled
    blank_lz = 1'b1;
    commit_value(16'h0050);
    check_frame("blank50", 7'h40, 7'h12, 7'h7F, 7'h7F);
    blank_lz = 1'b0;
    check_frame("noblank50", 7'h40, 7'h12, 7'h40, 7'h40);

    // Zero value with blanking
    blank_lz = 1'b1;
    commit_value(16'h0000);
    check_frame("blank0", 7'h40, 7'h7F, 7'h7F, 7'h7F);
    blank_lz = 1'b0;

    // Simultaneous load/commit: 1111 commits, 2222 stays pending for a frame
    go_frame();
    go_to(n + 1);
    value = 16'h1111;
    load  = 1'b1;
    cyc();
    load  = 1'b0;
    go_to(((n / 16) + 1) * 16 - 1);
    value = 16'h2222;
    load  = 1'b1;
    cyc();
    load  = 1'b0;
    check("sim_pending_stay", {15'h0, pending}, 16'h0001);
    check_frame("sim1111", 7'h79, 7'h79, 7'h79, 7'h79);
    check("sim_pending_frame", {15'h0, pending}, 16'h0001);
    go_frame();
    check("sim_pending_fall", {15'h0, pending}, 16'h0000);
    check_frame("sim2222", 7'h24, 7'h24, 7'h24, 7'h24);

    // Reset mid-operation discards pending BEEF
    go_to(n + 2);
    value = 16'hBEEF;
    load  = 1'b1;
    cyc();
    load  = 1'b0;
    check("beef_pending", {15'h0, pending}, 16'h0001);
    hold_reset(2);
    check_frame("post_rst_a", 7'h40, 7'h40, 7'h40, 7'h40);
    check_frame("post_rst_b", 7'h40, 7'h40, 7'h40, 7'h40);
    check("post_rst_pending", {15'h0, pending}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's 4-digit, common-anode 7-segment display. It sits downstream of the processor/data-memory I/O path in the FPGA top level, where it replaces the fixed anode tie-off. It accepts a 16-bit value on a load strobe and shows it as four hex digits with optional leading-zero blanking. New values are applied only at frame boundaries, so a partially updated number is never displayed.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit is lit. Legal range is ≥2. The prescaler width is $clog2(REFRESH_DIV).
- `clk`  input  1: system clock. All state changes on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `value`  input  16: value to display. Digit 0 is `value[3:0]` (rightmost); digit 3 is `value[15:12]`.
- `load`  input  1: when high on a rising edge, `value` is captured into the pending register.
- `blank_lz`  input  1: leading-zero blanking enable. It is sampled continuously and not latched.
- `pending`  output  1: high while a captured value has not yet been committed to the display.
- `an`  output  4: anode enables, active-low. Exactly one bit is low outside reset.
- `seg`  output  7: segments, active-low. `seg[0]`=a … `seg[6]`=g.

## Operation
- State:
  - prescaler `p`
  - digit index `d` (2 bits)
  - pending register `pv[15:0]` and its flag
  - display register `disp[15:0]`
  - output registers `an` and `seg`
- Reset clears all state to 0. During reset `an`=4'hF and `seg`=7'h7F (everything dark), and `pending`=0.
- Prescaler:
  - `p` increments every cycle.
  - When `p`==REFRESH_DIV-1, `p` wraps to 0 and a tick occurs.
  - On a tick, `d` advances modulo 4 (0→1→2→3→0).
- Load: `pv`<=`value` and flag<=1. Repeated loads before a commit overwrite `pv`; the last load wins.
- Commit: on a tick where `d`==3 (frame wrap), if the flag is set, `disp`<=`pv` and flag<=0.
- Simultaneous load and commit on the same edge:
  - The commit uses the `pv` held before that edge.
  - The new `value` is captured and the flag stays 1, so it commits at the next frame.
  - If the flag was 0, no commit happens and the new value becomes pending.
- Hex decode, `seg` in hex, digits 0–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Blanking:
  - When `blank_lz`=1, digit k (k=1..3) is blank (`seg`=7'h7F) if `disp` nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit still has its anode driven low.
- Output registers: `an`<=~(4'b0001<<`d`); `seg`<=decode/blank of `disp` nibble `d`.

## Timing
- `an`/`seg` have one cycle of latency: the outputs after edge n+1 reflect `d`, `disp` and `blank_lz` as held after edge n.
- First edge after `reset` falls: `an`=4'hE and `seg`=7'h40 (digit 0 showing '0').
- Each digit index is held for exactly REFRESH_DIV cycles. A full frame is 4·REFRESH_DIV cycles.
- Load-to-visible latency:
  - Minimum is 2 cycles (load captured on the edge just before a d==3 tick edge, plus output latency).
  - Maximum is one frame plus 1 cycle.
- `pending` is a registered flag. It rises on the load edge and falls on the commit edge.
- Reset asserted mid-frame: on the next edge the outputs go dark, `pv`, `disp` and `d` clear, and any pending value is discarded.

## Test plan
All scenarios use REFRESH_DIV=4 (frame = 16 cycles).
- **Reset/scan.** Hold reset for 3 cycles, then release. Expect `an`=F/`seg`=7F during reset. Then expect `an` to cycle E,D,B,7, each for 4 cycles, with `seg`=40 on every digit.
- **Load and commit.** Pulse load with `value`=16'h1A2F mid-frame while `d`=1. Expect `pending`=1 until the d==3 tick edge. In the next frame, expect `seg` per digit 0..3 = 0E,24,08,79.
- **Leading-zero blanking.** Commit 16'h0050 with `blank_lz`=1. Expect digits 0..3 `seg` = 40,12,7F,7F. Drop `blank_lz` and expect digit 3 to show 40 within one frame.
- **Value zero with blanking.** Commit 16'h0000 with `blank_lz`=1. Expect digit 0 `seg`=40 and digits 1–3 `seg`=7F.
- **Simultaneous load/commit.** Have 16'h1111 pending and load 16'h2222 on the commit edge. Expect the display to show 1111 for one frame, `pending` to stay 1, and 2222 to appear in the following frame.
- **Reset mid-operation.** Load 16'hBEEF, then assert reset before the commit. Expect `pending`=0, `disp`=0 and outputs dark. After release, expect '0' displayed and never BEEF.
